// File: rtl/seq_tag_alloc_pkg.sv
// Shared definitions for the sequence-tag allocator and the commit unit.
// Holds the default tag width, the tag bus type, the tag range limits and
// the allocator FSM state encodings.
package seq_tag_alloc_pkg;

    // Default tag width; the commit unit's cnt uses the same width.
    localparam int CntWidth = 4;

    // Tag bus type at the default width.
    typedef logic [CntWidth-1:0] CntBus;

    // Tag 0 means "no tag"; the last legal tag is all ones.
    localparam CntBus CntFirst = CntBus'(0);
    localparam CntBus CntLast  = CntBus'((1 << CntWidth) - 1);

    // RUN: normal issue. RECOVER: one dead cycle after a flush.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

endpackage

// File: rtl/seq_tag_inc.sv
// Wrapping sequence-tag incrementer.
// next(t) = (t == TAG_LAST) ? 1 : t + 1, so tag 0 is never produced.
// Purely combinational; shared by both allocator pointers and the commit unit.
module seq_tag_inc
    import seq_tag_alloc_pkg::*;
#(
    parameter int              W        = CntWidth,
    parameter logic [W-1:0]    TAG_LAST = W'(CntLast)
) (
    input  logic [W-1:0] tag,
    output logic [W-1:0] tag_next
);

    // Step to the next legal tag, skipping 0 on wrap.
    always_comb begin
        tag_next = tag + W'(1);
        if (tag == TAG_LAST) begin
            tag_next = W'(1);
        end
    end

endmodule

// File: rtl/seq_tag_alloc.sv
// Sequence-tag allocator and in-flight tracker.
// Hands out wrapping tags to the issue stage, tracks the commit head and the
// in-flight count, and back-pressures issue when DEPTH tags are outstanding.
//
// Optional feature: define SEQ_TAG_ALLOC_FLUSH_EN to add the i_flush port.
// A flush rewinds alloc_ptr to head_ptr, clears the count and spends one
// RECOVER cycle with grants blocked. Without the macro the FSM is fixed in RUN.
//
// Handshake: o_alloc_gnt is combinational from i_alloc_req and registered
// state; a tag is consumed on the rising clock edge where req and gnt are
// both 1. i_commit is a single-cycle strobe with no back-pressure; a commit
// that does not match o_head_tag (or arrives while empty) sets o_err.
module seq_tag_alloc
    import seq_tag_alloc_pkg::*;
#(
    parameter int CNT_WIDTH = CntWidth,
    parameter int DEPTH     = 8,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
    input  logic                 i_flush,
`endif
    input  logic                 i_alloc_req,
    output logic                 o_alloc_gnt,
    output logic [CNT_WIDTH-1:0] o_alloc_tag,
    input  logic                 i_commit,
    input  logic [CNT_WIDTH-1:0] i_commit_tag,
    output logic [CNT_WIDTH-1:0] o_head_tag,
    output logic [CW-1:0]        o_count,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_err
);

    // First tag after reset: one past the "no tag" value.
    localparam logic [CNT_WIDTH-1:0] TagInit  = CNT_WIDTH'(CntFirst) + CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TagLast  = CNT_WIDTH'((1 << CNT_WIDTH) - 1);
    localparam logic [CW-1:0]        CountMax = CW'(DEPTH);

    logic [CNT_WIDTH-1:0] alloc_ptr;
    logic [CNT_WIDTH-1:0] head_ptr;
    logic [CNT_WIDTH-1:0] alloc_ptr_inc;
    logic [CNT_WIDTH-1:0] head_ptr_inc;
    logic [CW-1:0]        count;
    logic                 err;

    logic full;
    logic empty;
    logic run;
    logic flush;
    logic grant;
    logic commit_hit;
    logic commit_ok;
    logic commit_bad;

    seq_tag_inc #(
        .W        (CNT_WIDTH),
        .TAG_LAST (TagLast)
    ) u_alloc_inc (
        .tag      (alloc_ptr),
        .tag_next (alloc_ptr_inc)
    );

    seq_tag_inc #(
        .W        (CNT_WIDTH),
        .TAG_LAST (TagLast)
    ) u_head_inc (
        .tag      (head_ptr),
        .tag_next (head_ptr_inc)
    );

`ifdef SEQ_TAG_ALLOC_FLUSH_EN
    state_e state;

    // RUN -> RECOVER on flush; RECOVER always returns to RUN after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (i_flush) begin
                        state <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign run   = (state == ST_RUN);
    assign flush = i_flush;
`else
    assign run   = 1'b1;
    assign flush = 1'b0;
`endif

    // Status derived from the registered count, so it lags a grant/commit by one cycle.
    assign full  = (count == CountMax);
    assign empty = (count == '0);

    // Grant uses registered full only: a same-cycle commit does not free a slot early.
    assign grant = i_alloc_req & ~full & run & ~flush;

    // A commit is good only when something is in flight and it retires the head.
    // Commits during a flush cycle are dropped silently.
    assign commit_hit = i_commit & ~empty & (i_commit_tag == head_ptr);
    assign commit_ok  = commit_hit & ~flush;
    assign commit_bad = i_commit & ~commit_hit & ~flush;

    // Pointer, count and sticky-error update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= TagInit;
            head_ptr  <= TagInit;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (commit_bad) begin
                err <= 1'b1;
            end
            if (flush) begin
                // Squash everything in flight: next issued tag restarts at the head.
                alloc_ptr <= head_ptr;
                count     <= '0;
            end else begin
                if (grant) begin
                    alloc_ptr <= alloc_ptr_inc;
                end
                if (commit_ok) begin
                    head_ptr <= head_ptr_inc;
                end
                case ({grant, commit_ok})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign o_alloc_gnt = grant;
    assign o_alloc_tag = alloc_ptr;
    assign o_head_tag  = head_ptr;
    assign o_count     = count;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_err       = err;

endmodule

// File: tb/tb_seq_tag_alloc.sv
// Testbench for seq_tag_alloc.
// The reference model keeps the in-flight tags as a plain queue, the next tag
// as an integer and the error as a flag. Each driven cycle pushes the expected
// status and (when a grant is expected) the expected tag; a monitor pops and
// compares away from the clock edge.
module tb_seq_tag_alloc;

    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MAXT  = (1 << W) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_alloc_req;
    logic          o_alloc_gnt;
    logic [W-1:0]  o_alloc_tag;
    logic          i_commit;
    logic [W-1:0]  i_commit_tag;
    logic [W-1:0]  o_head_tag;
    logic [CW-1:0] o_count;
    logic          o_full;
    logic          o_empty;
    logic          o_err;
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
    logic          i_flush;
`endif

    seq_tag_alloc #(
        .CNT_WIDTH (W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
        .i_flush      (i_flush),
`endif
        .i_alloc_req  (i_alloc_req),
        .o_alloc_gnt  (o_alloc_gnt),
        .o_alloc_tag  (o_alloc_tag),
        .i_commit     (i_commit),
        .i_commit_tag (i_commit_tag),
        .o_head_tag   (o_head_tag),
        .o_count      (o_count),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_err        (o_err)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        bit            gnt;
        logic [W-1:0]  atag;
        logic [W-1:0]  head;
        logic [CW-1:0] cnt;
        bit            full;
        bit            empty;
        bit            err;
    } status_t;

    logic [W-1:0] exp_q[$];
    status_t      stat_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_q[$];      // tags in flight, oldest first
    int m_next;      // tag the next grant will hand out
    bit m_err;
    bit m_recover;   // the cycle after a flush: no grant

    function automatic int m_inc(input int t);
        return (t % MAXT) + 1;
    endfunction

    function automatic int m_head();
        return (m_q.size() > 0) ? m_q[0] : m_next;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_next    = 1;
        m_err     = 1'b0;
        m_recover = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input bit req, input bit com, input int ctag, input bit fl);
        status_t s;
        bit g;
        bit fl_eff;
        @(negedge clk);
        fl_eff       = 1'b0;
        i_alloc_req  = req;
        i_commit     = com;
        i_commit_tag = W'(ctag);
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
        i_flush = fl;
        fl_eff  = fl;
`endif
        g       = req && (m_q.size() < DEPTH) && !m_recover && !fl_eff;
        s.gnt   = g;
        s.atag  = W'(m_next);
        s.head  = W'(m_head());
        s.cnt   = CW'(m_q.size());
        s.full  = (m_q.size() == DEPTH);
        s.empty = (m_q.size() == 0);
        s.err   = m_err;
        stat_q.push_back(s);
        if (g) exp_q.push_back(W'(m_next));
        if (fl_eff) begin
            m_next = m_head();
            m_q.delete();
            m_recover = 1'b1;
        end else begin
            m_recover = 1'b0;
            if (com) begin
                if (m_q.size() > 0 && m_q[0] == ctag) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (g) begin
                m_q.push_back(m_next);
                m_next = m_inc(m_next);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 0, 1'b0);
    endtask

    // Asserts reset between clock edges; asynchronous clear must show at once.
    task automatic do_reset();
        @(negedge clk);
        i_alloc_req  = 1'b0;
        i_commit     = 1'b0;
        i_commit_tag = '0;
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
        i_flush = 1'b0;
`endif
        rst = 1'b1;
        #1;
        check("rst_alloc_tag", o_alloc_tag, 1);
        check("rst_head_tag", o_head_tag, 1);
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_err", o_err, 0);
        check("rst_gnt", o_alloc_gnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            #2;
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check("gnt", o_alloc_gnt, s.gnt);
                check("alloc_tag", o_alloc_tag, s.atag);
                check("head_tag", o_head_tag, s.head);
                check("count", o_count, s.cnt);
                check("full", o_full, s.full);
                check("empty", o_empty, s.empty);
                check("err", o_err, s.err);
            end
            if (o_alloc_gnt === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", 1, 0);
                end else begin
                    check("gnt_tag", o_alloc_tag, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        rst          = 1'b1;
        i_alloc_req  = 1'b0;
        i_commit     = 1'b0;
        i_commit_tag = '0;
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
        i_flush = 1'b0;
`endif
        model_reset();

        // Fill: 10 requests, tags 1..8 granted, then blocked by full.
        do_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        // Drain in order: head ends at 9, empty, no error.
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, m_head(), 1'b0);
        idle(2);

        // Steady stream across the 15 -> 1 wrap with constant count.
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b1, m_head(), 1'b0);
        idle(1);

        // Full with request and valid commit in one cycle: no grant, then grant.
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        drive_cycle(1'b1, 1'b1, m_head(), 1'b0);
        drive_cycle(1'b1, 1'b0, 0, 1'b0);
        idle(1);

        // Out-of-order commit sets the sticky error and leaves the head alone.
        do_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        drive_cycle(1'b0, 1'b1, 3, 1'b0);
        drive_cycle(1'b0, 1'b1, 1, 1'b0);
        idle(2);
        // Commit while empty.
        do_reset();
        drive_cycle(1'b0, 1'b1, 1, 1'b0);
        idle(2);

`ifdef SEQ_TAG_ALLOC_FLUSH_EN
        // Five in flight with head 4, flush (with an ignored commit), then recover.
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, m_head(), 1'b0);
        drive_cycle(1'b1, 1'b1, m_head(), 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 0, 1'b0);
        idle(1);
`endif

        // Randomized traffic, in-order commits only; reset lands mid-operation.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit req;
            bit com;
            bit fl;
            req = ($urandom_range(0, 3) != 0);
            com = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            fl  = 1'b0;
`ifdef SEQ_TAG_ALLOC_FLUSH_EN
            fl = !m_recover && ($urandom_range(0, 29) == 0);
`endif
            drive_cycle(req, com, m_head(), fl);
            if (i == 150) do_reset();
        end
        idle(1);

        // Randomized traffic with occasional wrong or spurious commits.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            bit req;
            bit com;
            int tg;
            req = ($urandom_range(0, 1) != 0);
            r   = $urandom_range(0, 19);
            com = (r < 10);
            tg  = (r == 0) ? $urandom_range(0, MAXT) : m_head();
            if (m_q.size() == 0 && r != 0) com = 1'b0;
            drive_cycle(req, com, tg, 1'b0);
        end
        idle(2);

        @(negedge clk);
        #3;
        check("stat_q_drained", stat_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_tag_alloc.md
# seq_tag_alloc

Sequence-tag allocator and in-flight tracker for the out-of-order core. Sits between the issue stage and the commit unit. Hands each issued instruction a wrapping sequence tag (the `cnt` value execution units return with their results), tracks the expected commit head and the in-flight count, and back-pressures issue when the commit window is full. Its head tag and wrap rule match the commit unit's `cnt` exactly.

## Interface
- `CNT_WIDTH`, default 4: tag width. Legal tags are 1..2^CNT_WIDTH-1; 0 means "no tag".
- `DEPTH`, default 8: maximum in-flight tags. Must satisfy 1 ≤ DEPTH ≤ 2^CNT_WIDTH-2.
- `clk` input 1: clock.
- `rst` input 1: reset. Asynchronous, active-high.
- `i_alloc_req` input 1: issue stage requests a tag this cycle.
- `o_alloc_gnt` output 1: grant (combinational).
- `o_alloc_tag` output CNT_WIDTH: tag handed out when `o_alloc_gnt`=1. Always shows the next tag.
- `i_commit` input 1: commit unit retired one instruction this cycle.
- `i_commit_tag` input CNT_WIDTH: tag of the retired instruction.
- `o_head_tag` output CNT_WIDTH: oldest in-flight tag, i.e. the expected next commit.
- `o_count` output clog2(DEPTH+1): in-flight count.
- `o_full` output 1: `o_count` == DEPTH.
- `o_empty` output 1: `o_count` == 0.
- `o_err` output 1: sticky protocol error.
- `i_flush` input 1: squash all in-flight tags. Present only with `SEQ_TAG_ALLOC_FLUSH_EN`.

## Operation
- Registers: `alloc_ptr`, `head_ptr`, `count`, `err`, and a 2-state FSM `RUN`/`RECOVER`.
- Tag increment: next(t) = (t == 2^CNT_WIDTH-1) ? 1 : t+1. Tag 0 is never produced.
- `o_alloc_gnt` = `i_alloc_req` & ~`o_full` & (state == `RUN`).
- Grant: `alloc_ptr` ← next(`alloc_ptr`).
- Valid commit (`i_commit` & ~`o_empty` & `i_commit_tag` == `head_ptr`): `head_ptr` ← next(`head_ptr`).
- Invalid commit: if `i_commit` with `o_empty`=1 or a tag mismatch, set `err`=1 and leave pointers and count unchanged. `err` clears only on `rst`.
- Count update: +1 on grant only, −1 on valid commit only, unchanged when both occur.
- Full with a commit in the same cycle: no grant that cycle. Grant uses the registered `o_full` (no bypass).
- Invariant: `alloc_ptr` equals `head_ptr` advanced `count` times.
- FSM: `RUN`→`RECOVER` on flush. `RECOVER`→`RUN` unconditionally after 1 cycle.

## Timing
- Reset values: `alloc_ptr`=1, `head_ptr`=1, `count`=0, `err`=0, state `RUN`.
- Outputs after reset: `o_alloc_tag`=1, `o_head_tag`=1, `o_count`=0, `o_empty`=1, `o_full`=0, `o_err`=0, `o_alloc_gnt`=`i_alloc_req`.
- Grant is combinational in the same cycle as the request. The tag is consumed at that clock edge.
- `o_count`/`o_full`/`o_empty` reflect the grant or commit one cycle later.
- Reset asserted mid-operation returns all state to reset values immediately.

## Configuration
- `SEQ_TAG_ALLOC_FLUSH_EN` defined:
  - `i_flush` port exists.
  - On flush, `alloc_ptr` ← `head_ptr`, `count` ← 0, FSM → `RECOVER`. No grant in the flush cycle or the `RECOVER` cycle.
  - A commit in the flush cycle is ignored, with no error.
- Not defined: no `i_flush` port, FSM stays in `RUN`, and the `RECOVER` logic is removed.

## Structure
- Shared defines header:
  - `CntWidth` / `CntBus`, kept consistent with the commit unit.
  - `CntFirst` = 0 and `CntLast` = 2^CntWidth-1.
  - FSM state encodings.
- Sub-module `seq_tag_inc`: combinational wrapping incrementer, instantiated for both pointers and reusable by the commit unit.

## Test plan
- Reset, then hold `i_alloc_req`=1 for 10 cycles → grants with tags 1..8. `o_full`=1 after the 8th. No grant on cycles 9–10.
- Allocate 8, commit tags 1..8 in order → `o_empty`=1, `o_head_tag`=9, `o_err`=0.
- Steady stream of 1 alloc + 1 commit per cycle for 20 cycles → `o_count` constant. Tag sequence …14,15,1,2… with 0 never issued.
- Full (count 8) with `i_alloc_req` and a valid commit in the same cycle → no grant, `o_count`=7 next cycle, grant in the following cycle.
- Commit tag 3 while head is 1 → `o_err`=1 and stays 1, `o_head_tag` still 1. Commit while empty → `o_err`=1.
- (Flush enabled) 5 in flight, head=4, assert `i_flush` → next cycle `o_count`=0, `o_alloc_tag`=4, no grant for 2 cycles, grant resumes at tag 4.
